exec_controller: RTL and testbench

Execution controller for the microprocessor core on the board. It turns a raw push-button and a run switch into a single-cycle clock-enable `cpu_en` for the core, so the core always runs on one clock. It supports single-step, free-run at a programmable rate, and an optional PC breakpoint, and it counts issued instructions. It sits between the board I/O wrapper and the core's enable input.

---
 rtl/exec_ctrl_pkg.sv | 19 +
 rtl/key_debounce.sv | 57 +++++
 rtl/exec_controller.sv | 122 ++++++++++++
 tb/tb_exec_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared encodings and defaults for the execution controller and its key debouncer.
package exec_ctrl_pkg;

    localparam int STATE_W                 = 2;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } exec_state_t;

    // The core is considered stopped whenever it is waiting for the operator.
    function automatic logic is_halted(exec_state_t s);
        return (s == ST_HALT) || (s == ST_BREAK);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop sync + stability counter; press pulses 1 cycle after the stable level falls.
// Key latency is 2 sync cycles + DEBOUNCE_CYCLES; no backpressure, press is a fire-and-forget pulse.
module key_debounce
    import exec_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Any cycle agreeing with the stable level restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/exec_controller.sv
// exec_controller: step/run/breakpoint FSM producing a registered one-cycle cpu_en, no backpressure.
// The PC breakpoint is built only when EXEC_CTRL_BREAKPOINT_EN is defined.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH       = 4,
    parameter int DIV_WIDTH       = 26,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_n,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div_load,
    input  logic [BIT_WIDTH-1:0] pc,
    input  logic [BIT_WIDTH-1:0] bp_addr,
    input  logic                 bp_en,
    output logic                 cpu_en,
    output logic [STATE_W-1:0]   state,
    output logic                 halted,
    output logic [15:0]          cycle_count
);

    logic press;
    logic bp_hit;
    logic tick;

    exec_state_t          state_q, state_d;
    logic                 cpu_en_q, cpu_en_d;
    logic                 halted_q, halted_d;
    logic [15:0]          count_q, count_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (step_n),
        .press (press)
    );

`ifdef EXEC_CTRL_BREAKPOINT_EN
    assign bp_hit = bp_en && (pc == bp_addr);
`else
    logic bp_unused;
    assign bp_unused = ^{bp_en, bp_addr, pc};
    assign bp_hit    = 1'b0;
`endif

    assign tick = (div_q == '0);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cpu_en_d = 1'b0;
        count_d  = cpu_en_q ? count_q + 16'd1 : count_q;
        case (state_q)
            ST_HALT: begin
                if (run) begin
                    state_d = ST_RUN;
                    div_d   = div_load;
                end else if (press) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_RUN: begin
                // Dropping run wins over a tick in the same cycle.
                if (!run) begin
                    state_d = ST_HALT;
                end else if (tick) begin
                    if (bp_hit) begin
                        state_d = ST_BREAK;
                    end else begin
                        cpu_en_d = 1'b1;
                        div_d    = div_load;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            ST_BREAK: begin
                if (!run) begin
                    state_d = ST_HALT;
                end else if (press) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        halted_d = is_halted(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_HALT;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b1;
            count_q  <= 16'd0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            halted_q <= halted_d;
            count_q  <= count_d;
            div_q    <= div_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller with a 4-cycle debounce and randomized run/step stimulus.
module tb_exec_controller;

    localparam int BW = 4;
    localparam int DW = 26;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          step_n;
    logic          run;
    logic [DW-1:0] div_load;
    logic [BW-1:0] pc;
    logic [BW-1:0] bp_addr;
    logic          bp_en;
    logic          cpu_en;
    logic [1:0]    state;
    logic          halted;
    logic [15:0]   cycle_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_count;

    exec_controller #(
        .BIT_WIDTH      (BW),
        .DIV_WIDTH      (DW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_n     (step_n),
        .run        (run),
        .div_load   (div_load),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .cpu_en     (cpu_en),
        .state      (state),
        .halted     (halted),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; step_n = 1'b1; div_load = '0;
        pc = '0; bp_addr = '0; bp_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state cyc%0d got %0d exp 0", i, state); end
            checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en cyc%0d got %b exp 0", i, cpu_en); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted cyc%0d got %b exp 1", i, halted); end
            checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count cyc%0d got %0d exp 0", i, cycle_count); end
        end
        run = 1'b0;
        rst = 1'b1;
        exp_count = 16'd0;
        tick();
    endtask

    task automatic test_step();
        int pulses;
        int rel_pulses;
        for (int it = 0; it < 3; it++) begin
            pulses = 0;
            rel_pulses = 0;
            for (int i = 0; i < 3; i++) begin
                step_n = 1'($urandom_range(0, 1));
                tick();
                if (cpu_en === 1'b1) pulses++;
            end
            step_n = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (cpu_en === 1'b1) begin
                    pulses++;
                    checks++; if (state !== 2'b01) begin errors++; $display("FAIL step_pulse_state got %0d exp 1", state); end
                end
            end
            step_n = 1'b1;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (cpu_en === 1'b1) rel_pulses++;
            end
            exp_count = exp_count + 16'd1;
            checks++; if (pulses !== 1) begin errors++; $display("FAIL step_pulses it%0d got %0d exp 1", it, pulses); end
            checks++; if (rel_pulses !== 0) begin errors++; $display("FAIL step_release it%0d got %0d exp 0", it, rel_pulses); end
            checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL step_count it%0d got %0d exp %0d", it, cycle_count, exp_count); end
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL step_end_state it%0d got %0d exp 0", it, state); end
        end
    endtask

    task automatic test_run();
        int l;
        int m;
        int n;
        int npulse;
        int bad;
        logic exp_en;
        for (int it = 0; it < 4; it++) begin
            l = (it == 0) ? 3 : $urandom_range(0, 6);
            m = (it == 0) ? 4 : $urandom_range(1, 4);
            // Run length chosen so run drops in a cycle where the divider has expired.
            n = (m + 1) * (l + 1);
            npulse = 0;
            bad = 0;
            div_load = DW'(l);
            pc = '0; bp_en = 1'b0;
            run = 1'b1;
            for (int k = 1; k <= n; k++) begin
                tick();
                exp_en = (k >= l + 2) && (((k - (l + 2)) % (l + 1)) == 0);
                if (exp_en) npulse++;
                if (cpu_en !== exp_en || state !== 2'b10 || halted !== 1'b0) begin
                    bad++;
                    $display("FAIL run_cycle L%0d k%0d cpu_en %b exp %b state %0d halted %b", l, k, cpu_en, exp_en, state, halted);
                end
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL run_pattern L%0d got %0d bad cycles exp 0", l, bad); end
            run = 1'b0;
            tick();
            checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL run_drop_pulse L%0d got %b exp 0", l, cpu_en); end
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL run_drop_state L%0d got %0d exp 0", l, state); end
            tick();
            exp_count = exp_count + 16'(npulse);
            checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL run_count L%0d got %0d exp %0d", l, cycle_count, exp_count); end
            if (it == 0) begin
                checks++; if (npulse !== 4) begin errors++; $display("FAIL run_model_pulses got %0d exp 4", npulse); end
            end
        end
    endtask

    task automatic test_breakpoint();
        int pulses;
        int late;
        div_load = DW'($urandom_range(0, 3));
        bp_en = 1'b1; bp_addr = 4'h5; pc = '0;
        pulses = 0;
        run = 1'b1;
`ifdef EXEC_CTRL_BREAKPOINT_EN
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cpu_en === 1'b1) begin pulses++; pc = pc + 1'b1; end
            if (state === 2'b11 || pulses > 8) break;
        end
        checks++; if (pulses !== 5) begin errors++; $display("FAIL bp_pulses got %0d exp 5", pulses); end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL bp_state got %0d exp 3", state); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted got %b exp 1", halted); end
        late = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (cpu_en === 1'b1) late++; end
        checks++; if (late !== 0 || state !== 2'b11) begin errors++; $display("FAIL bp_hold pulses %0d state %0d exp 0 pulses state 3", late, state); end
        step_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (state === 2'b01) break;
        end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL bp_step_state got %0d exp 1", state); end
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL bp_step_pulse got %b exp 1", cpu_en); end
        run = 1'b0;
        pc = pc + 1'b1;
        tick();
        checks++; if (state !== 2'b00 || cpu_en !== 1'b0) begin errors++; $display("FAIL bp_after_step state %0d cpu_en %b exp 0 0", state, cpu_en); end
        step_n = 1'b1;
        late = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (cpu_en === 1'b1) late++; end
        checks++; if (late !== 0) begin errors++; $display("FAIL bp_release got %0d pulses exp 0", late); end
        exp_count = exp_count + 16'd6;
`else
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cpu_en === 1'b1) begin pulses++; pc = pc + 1'b1; end
            if (pulses >= 8) break;
        end
        run = 1'b0;
        checks++; if (pulses !== 8) begin errors++; $display("FAIL nobp_pulses got %0d exp 8", pulses); end
        checks++; if (state !== 2'b10 || halted !== 1'b0) begin errors++; $display("FAIL nobp_state got %0d halted %b exp 2 0", state, halted); end
        late = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (cpu_en === 1'b1) late++; end
        checks++; if (late !== 0 || state !== 2'b00) begin errors++; $display("FAIL nobp_stop pulses %0d state %0d exp 0 0", late, state); end
        exp_count = exp_count + 16'd8;
`endif
        bp_en = 1'b0;
        checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL bp_count got %0d exp %0d", cycle_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        div_load = '0;
        run = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run = 1'b0;
        exp_count = 16'd0;
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL midrst_cpu_en got %b exp 0", cpu_en); end
        checks++; if (state !== 2'b00 || halted !== 1'b1) begin errors++; $display("FAIL midrst_state got %0d halted %b exp 0 1", state, halted); end
        checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL midrst_count got %0d exp 0", cycle_count); end
        tick();
    endtask

    task automatic test_wrap();
        div_load = '0;
        bp_en = 1'b0;
        run = 1'b1;
        // With a zero divider pulses start 2 cycles after run and repeat every cycle.
        for (int k = 1; k <= 65538; k++) begin
            tick();
            if (k == 65536) begin
                checks++; if (cycle_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_fffe got %h exp fffe", cycle_count); end
            end
            if (k == 65537) begin
                checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", cycle_count); end
            end
            if (k == 65538) begin
                checks++; if (cycle_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", cycle_count); end
            end
        end
        run = 1'b0;
        tick();
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL wrap_stop_state got %0d exp 0", state); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_breakpoint();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
